// File: rtl/temp_sense_poll_pkg.sv
// Shared types and constants for the two-sensor temperature poller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package temp_sense_poll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ACK_A,
        READ,
        MNACK,
        STOP,
        NEXT
    } state_t;

    localparam int         PHASE_W   = 2;
    localparam logic       RD_BIT    = 1'b1;
    localparam logic [7:0] NACK_FILL = 8'hFF;

endpackage

// File: rtl/temp_sense_poll_tick.sv
// tick_div: free-running 0..DIV-1 counter, one-cycle tick on the wrap count.
// Latency: tick is combinational from the count register (first tick DIV-1 cycles after reset).
// Backpressure: none; free-running.
module tick_div #(
    parameter int           W   = 8,
    parameter logic [W-1:0] DIV = W'(4)
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick
);

    localparam logic [W-1:0] LAST = DIV - 1'b1;

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/temp_sense_poll.sv
// Autonomous two-wire master polling one byte from each of two sensors; optional TEMP_OVERTEMP_EN adds overtemp.
// Latency: 80 qticks per sensor, results latched at STOP completion; bus outputs registered (1 cycle).
// Backpressure: none; poll wraps seen while busy are dropped, not queued.
module temp_sense_poll
    import temp_sense_poll_pkg::*;
#(
    parameter int          CLK_DIV     = 123,
    parameter logic [23:0] POLL_PERIOD = 24'd4915200,
    parameter logic [6:0]  ADDR0       = 7'h48,
    parameter logic [6:0]  ADDR1       = 7'h49
`ifdef TEMP_OVERTEMP_EN
    ,
    parameter logic [7:0]  OT_LIMIT    = 8'd80
`endif
) (
    input  logic        sysclk,
    input  logic        reset,
    output logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    output logic [15:0] temp_sense,
    output logic        temp_valid,
    output logic [1:0]  temp_err,
    output logic        overtemp
);

    localparam int QDIV_W = $clog2(CLK_DIV + 1);

    state_t               state, state_nxt;
    logic [PHASE_W-1:0]   q;
    logic [2:0]           bit_cnt;
    logic                 sensor;
    logic [7:0]           shreg;
    logic                 nack;
    logic                 qtick, poll_tick;
    logic                 scl_c, sda_c;
    logic                 phase_end, sample, bit_clk;
    logic [7:0]           rd_byte;

    tick_div #(.W(QDIV_W), .DIV(QDIV_W'(CLK_DIV))) u_qdiv (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (qtick)
    );

    tick_div #(.W(24), .DIV(POLL_PERIOD)) u_poll (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (poll_tick)
    );

    assign phase_end = qtick && (q == 2'd3);
    assign sample    = qtick && (q == 2'd2);
    assign bit_clk   = (q == 2'd1) || (q == 2'd2);
    assign rd_byte   = nack ? NACK_FILL : shreg;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_c     = 1'b1;
        sda_c     = 1'b0;
        case (state)
            IDLE: begin
                if (poll_tick) state_nxt = START;
            end
            START: begin
                scl_c = (q != 2'd3);
                sda_c = (q != 2'd0);
                if (phase_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl_c = bit_clk;
                sda_c = ~shreg[7];
                if (phase_end && bit_cnt == 3'd7) state_nxt = ACK_A;
            end
            ACK_A: begin
                scl_c = bit_clk;
                if (phase_end) state_nxt = nack ? STOP : READ;
            end
            READ: begin
                scl_c = bit_clk;
                if (phase_end && bit_cnt == 3'd7) state_nxt = MNACK;
            end
            MNACK: begin
                scl_c = bit_clk;
                if (phase_end) state_nxt = STOP;
            end
            STOP: begin
                scl_c = (q != 2'd0);
                sda_c = (q != 2'd3);
                if (phase_end) state_nxt = NEXT;
            end
            NEXT: begin
                state_nxt = sensor ? IDLE : START;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            scl        <= 1'b1;
            sda_oe     <= 1'b0;
            q          <= '0;
            bit_cnt    <= '0;
            sensor     <= 1'b0;
            shreg      <= '0;
            nack       <= 1'b0;
            temp_sense <= '0;
            temp_valid <= 1'b0;
            temp_err   <= '0;
        end else begin
            scl    <= scl_c;
            sda_oe <= sda_c;
            // Quarter index only runs inside bus phases so every phase starts at q0.
            if (state == IDLE || state == NEXT) begin
                q <= '0;
            end else if (qtick) begin
                q <= q + 1'b1;
            end
            case (state)
                IDLE: sensor <= 1'b0;
                START: begin
                    if (phase_end) begin
                        shreg   <= {sensor ? ADDR1 : ADDR0, RD_BIT};
                        bit_cnt <= '0;
                        nack    <= 1'b0;
                    end
                end
                ADDR: begin
                    if (phase_end) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ACK_A: begin
                    if (sample) nack <= sda_in;
                end
                READ: begin
                    if (sample) shreg <= {shreg[6:0], sda_in};
                    if (phase_end) bit_cnt <= bit_cnt + 1'b1;
                end
                STOP: begin
                    if (phase_end) begin
                        if (sensor) begin
                            temp_sense[15:8] <= rd_byte;
                            temp_valid       <= 1'b1;
                        end else begin
                            temp_sense[7:0]  <= rd_byte;
                        end
                        temp_err[sensor] <= nack;
                    end
                end
                NEXT: sensor <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef TEMP_OVERTEMP_EN
    logic ot_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ot_q <= 1'b0;
        end else if (state == STOP && phase_end && !nack && shreg >= OT_LIMIT) begin
            ot_q <= 1'b1;
        end
    end

    assign overtemp = ot_q;
`else
    assign overtemp = 1'b0;
`endif

endmodule

// File: tb/tb_temp_sense_poll.sv
// Bench for temp_sense_poll: two-address sensor model on the bus, scoreboard of transactions and results.
module tb_temp_sense_poll;

    localparam int          CLK_DIV = 4;
    localparam logic [23:0] POLL    = 24'd100;
`ifdef TEMP_OVERTEMP_EN
    localparam logic OT_EN = 1'b1;
`else
    localparam logic OT_EN = 1'b0;
`endif

    typedef struct { logic [7:0] addr; logic [7:0] rises; int start; } txn_t;
    typedef struct { logic [15:0] ts; logic [1:0] err; logic valid; logic ot; } res_t;
    typedef enum int { M_IDLE, M_ADDR, M_ACK, M_DATA } m_st_t;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;
    logic        scl, sda_oe, sda_line, temp_valid, overtemp;
    logic [15:0] temp_sense;
    logic [1:0]  temp_err;

    logic [7:0] data0, data1;
    logic       ack0, ack1;
    logic       slave_low, scl_p, sda_p, m_sel;
    logic [7:0] m_addr, m_tx, m_rises;
    m_st_t      m_st;
    int         m_cnt, m_start, last_rise, scl_per, bus_viol, cyc;

    txn_t exp_q[$], obs_q[$];
    res_t res_q[$];
    txn_t o, e;
    res_t r;
    int   total = 0;
    int   bad   = 0;

    assign sda_line = ~(sda_oe | slave_low);

    always #5 sysclk = ~sysclk;

    initial cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    temp_sense_poll #(
        .CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL), .ADDR0(7'h48), .ADDR1(7'h49)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .scl        (scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .temp_sense (temp_sense),
        .temp_valid (temp_valid),
        .temp_err   (temp_err),
        .overtemp   (overtemp)
    );

    // Sensor model plus bus monitor: sees the bus one cycle late, answers on SCL falling edges.
    always @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            m_st <= M_IDLE; slave_low <= 1'b0; scl_p <= 1'b1; sda_p <= 1'b1;
            m_cnt <= 0; m_rises <= 8'd0; m_addr <= 8'd0; m_tx <= 8'd0; m_sel <= 1'b0;
        end else begin
            scl_p <= scl;
            sda_p <= sda_line;
            if (scl_p && scl && sda_p && !sda_line) begin
                m_st <= M_ADDR; m_cnt <= 0; m_rises <= 8'd0; m_start <= cyc; slave_low <= 1'b0;
            end else if (scl_p && scl && !sda_p && sda_line) begin
                obs_q.push_back('{addr: m_addr, rises: m_rises, start: m_start});
                m_st <= M_IDLE; slave_low <= 1'b0;
            end else begin
                if (scl != scl_p && sda_line != sda_p) bus_viol <= bus_viol + 1;
                if (!scl_p && scl) m_rises <= m_rises + 8'd1;
                case (m_st)
                    M_ADDR: begin
                        if (!scl_p && scl) begin
                            m_addr <= {m_addr[6:0], sda_line};
                            m_cnt  <= m_cnt + 1;
                            if (m_cnt > 0) scl_per <= cyc - last_rise;
                            last_rise <= cyc;
                        end else if (scl_p && !scl && m_cnt == 8) begin
                            if (m_addr[0] && ((m_addr[7:1] == 7'h48 && ack0) || (m_addr[7:1] == 7'h49 && ack1))) begin
                                slave_low <= 1'b1;
                                m_sel     <= (m_addr[7:1] == 7'h49);
                                m_st      <= M_ACK;
                            end else begin
                                m_st <= M_IDLE;
                            end
                        end
                    end
                    M_ACK: begin
                        if (scl_p && !scl) begin
                            m_tx      <= m_sel ? data1 : data0;
                            slave_low <= m_sel ? ~data1[7] : ~data0[7];
                            m_cnt     <= 0;
                            m_st      <= M_DATA;
                        end
                    end
                    M_DATA: begin
                        if (scl_p && !scl) begin
                            if (m_cnt == 7) begin
                                slave_low <= 1'b0;
                                m_st      <= M_IDLE;
                            end else begin
                                slave_low <= ~m_tx[6];
                                m_tx      <= {m_tx[6:0], 1'b0};
                            end
                            m_cnt <= m_cnt + 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic wait_obs(input int n);
        int k = 0;
        while (obs_q.size() < n && k < 3000) begin
            @(posedge sysclk);
            k++;
        end
        total++;
        if (obs_q.size() < n) begin
            bad++;
            $display("FAIL wait_obs: got %0d transactions, required %0d within 3000 cycles", obs_q.size(), n);
        end
        repeat (10) @(posedge sysclk);
        #1;
    endtask

    task automatic test_reset();
        data0 = 8'h1E; data1 = 8'h2A; ack0 = 1'b1; ack1 = 1'b1;
        bus_viol = 0; scl_per = 0; last_rise = 0; m_start = 0;
        repeat (3) @(posedge sysclk);
        #1;
        total++; if (scl !== 1'b1)         begin bad++; $display("FAIL reset scl: got %b want 1", scl); end
        total++; if (sda_oe !== 1'b0)      begin bad++; $display("FAIL reset sda_oe: got %b want 0", sda_oe); end
        total++; if (temp_sense !== 16'h0) begin bad++; $display("FAIL reset temp_sense: got %h want 0000", temp_sense); end
        total++; if (temp_valid !== 1'b0)  begin bad++; $display("FAIL reset temp_valid: got %b want 0", temp_valid); end
        total++; if (temp_err !== 2'b00)   begin bad++; $display("FAIL reset temp_err: got %b want 00", temp_err); end
        total++; if (overtemp !== 1'b0)    begin bad++; $display("FAIL reset overtemp: got %b want 0", overtemp); end
        @(negedge sysclk);
        reset = 1'b1;
    endtask

    task automatic test_first_poll();
        exp_q.push_back('{addr: 8'h91, rises: 8'd19, start: 0});
        exp_q.push_back('{addr: 8'h93, rises: 8'd19, start: 0});
        res_q.push_back('{ts: 16'h2A1E, err: 2'b00, valid: 1'b1, ot: 1'b0});
        wait_obs(1);
        total++;
        if (temp_sense !== 16'h001E || temp_valid !== 1'b0) begin
            bad++; $display("FAIL first_poll mid: got ts=%h vld=%b want ts=001E vld=0", temp_sense, temp_valid);
        end
        wait_obs(2);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o.addr !== e.addr || o.rises !== e.rises) begin
                bad++; $display("FAIL first_poll txn: got addr=%h rises=%0d want addr=%h rises=%0d", o.addr, o.rises, e.addr, e.rises);
            end
        end
        r = res_q.pop_front(); total++;
        if ({temp_sense, temp_err, temp_valid, overtemp} !== {r.ts, r.err, r.valid, r.ot}) begin
            bad++; $display("FAIL first_poll result: got ts=%h err=%b vld=%b ot=%b want ts=%h err=%b vld=%b ot=%b",
                            temp_sense, temp_err, temp_valid, overtemp, r.ts, r.err, r.valid, r.ot);
        end
        total++;
        if (scl_per !== 4 * CLK_DIV) begin bad++; $display("FAIL scl_period: got %0d want %0d", scl_per, 4 * CLK_DIV); end
    endtask

    task automatic test_addr_nack();
        ack1 = 1'b0;
        exp_q.push_back('{addr: 8'h91, rises: 8'd19, start: 0});
        exp_q.push_back('{addr: 8'h93, rises: 8'd10, start: 0});
        res_q.push_back('{ts: 16'hFF1E, err: 2'b10, valid: 1'b1, ot: 1'b0});
        wait_obs(2);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o.addr !== e.addr || o.rises !== e.rises) begin
                bad++; $display("FAIL addr_nack txn: got addr=%h rises=%0d want addr=%h rises=%0d", o.addr, o.rises, e.addr, e.rises);
            end
        end
        r = res_q.pop_front(); total++;
        if ({temp_sense, temp_err, temp_valid, overtemp} !== {r.ts, r.err, r.valid, r.ot}) begin
            bad++; $display("FAIL addr_nack result: got ts=%h err=%b vld=%b ot=%b want ts=%h err=%b vld=%b ot=%b",
                            temp_sense, temp_err, temp_valid, overtemp, r.ts, r.err, r.valid, r.ot);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0 [2] = '{8'h33, 8'h12};
        logic [7:0] d1 [2] = '{8'h44, 8'h07};
        int s0 [2];
        ack1 = 1'b1;
        for (int p = 0; p < 2; p++) begin
            data0 = d0[p]; data1 = d1[p];
            exp_q.push_back('{addr: 8'h91, rises: 8'd19, start: 0});
            exp_q.push_back('{addr: 8'h93, rises: 8'd19, start: 0});
            res_q.push_back('{ts: {d1[p], d0[p]}, err: 2'b00, valid: 1'b1, ot: 1'b0});
            wait_obs(2);
            s0[p] = 0;
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
                if (o.addr == 8'h91) s0[p] = o.start;
                if (o.addr !== e.addr || o.rises !== e.rises) begin
                    bad++; $display("FAIL b2b txn: got addr=%h rises=%0d want addr=%h rises=%0d", o.addr, o.rises, e.addr, e.rises);
                end
            end
            r = res_q.pop_front(); total++;
            if ({temp_sense, temp_err, temp_valid, overtemp} !== {r.ts, r.err, r.valid, r.ot}) begin
                bad++; $display("FAIL b2b result: got ts=%h err=%b vld=%b ot=%b want ts=%h err=%b vld=%b ot=%b",
                                temp_sense, temp_err, temp_valid, overtemp, r.ts, r.err, r.valid, r.ot);
            end
        end
        total++;
        if ((s0[1] - s0[0]) % int'(POLL) != 0 || (s0[1] - s0[0]) < 700) begin
            bad++; $display("FAIL b2b poll_gap: got %0d cycles, want a multiple of %0d and at least 700", s0[1] - s0[0], POLL);
        end
        total++;
        if (bus_viol !== 0) begin bad++; $display("FAIL bus_monitor: got %0d simultaneous SCL/SDA changes want 0", bus_viol); end
    endtask

    task automatic test_overtemp();
        logic       ak [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] dv [4] = '{8'd80, 8'd79, 8'd80, 8'd20};
        logic       ot [4];
        ot = '{1'b0, 1'b0, OT_EN, OT_EN};
        for (int p = 0; p < 4; p++) begin
            ack0 = ak[p]; data0 = dv[p];
            exp_q.push_back('{addr: 8'h91, rises: ak[p] ? 8'd19 : 8'd10, start: 0});
            exp_q.push_back('{addr: 8'h93, rises: 8'd19, start: 0});
            res_q.push_back('{ts: {8'h07, ak[p] ? dv[p] : 8'hFF}, err: {1'b0, ~ak[p]}, valid: 1'b1, ot: ot[p]});
            wait_obs(2);
            while (obs_q.size() > 0 && exp_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
                if (o.addr !== e.addr || o.rises !== e.rises) begin
                    bad++; $display("FAIL overtemp txn: got addr=%h rises=%0d want addr=%h rises=%0d", o.addr, o.rises, e.addr, e.rises);
                end
            end
            r = res_q.pop_front(); total++;
            if ({temp_sense, temp_err, temp_valid, overtemp} !== {r.ts, r.err, r.valid, r.ot}) begin
                bad++; $display("FAIL overtemp result %0d: got ts=%h err=%b vld=%b ot=%b want ts=%h err=%b vld=%b ot=%b",
                                p, temp_sense, temp_err, temp_valid, overtemp, r.ts, r.err, r.valid, r.ot);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        data0 = 8'h35; data1 = 8'h46; ack0 = 1'b1; ack1 = 1'b1;
        while (!(m_st == M_DATA && !m_sel && m_cnt == 3 && scl === 1'b0) && k < 3000) begin
            @(posedge sysclk);
            k++;
        end
        total++;
        if (k >= 3000) begin bad++; $display("FAIL reset_mid wait: got no sensor-0 READ within 3000 cycles, required one"); end
        #1 reset = 1'b0;
        #1;
        total++;
        if (scl !== 1'b1 || sda_oe !== 1'b0) begin bad++; $display("FAIL reset_mid bus: got scl=%b sda_oe=%b want 1/0", scl, sda_oe); end
        total++;
        if (temp_sense !== 16'h0 || temp_valid !== 1'b0 || overtemp !== 1'b0) begin
            bad++; $display("FAIL reset_mid regs: got ts=%h vld=%b ot=%b want 0000/0/0", temp_sense, temp_valid, overtemp);
        end
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        exp_q.push_back('{addr: 8'h91, rises: 8'd19, start: 0});
        exp_q.push_back('{addr: 8'h93, rises: 8'd19, start: 0});
        res_q.push_back('{ts: 16'h4635, err: 2'b00, valid: 1'b1, ot: 1'b0});
        wait_obs(2);
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); total++;
            if (o.addr !== e.addr || o.rises !== e.rises) begin
                bad++; $display("FAIL reset_mid txn: got addr=%h rises=%0d want addr=%h rises=%0d", o.addr, o.rises, e.addr, e.rises);
            end
        end
        r = res_q.pop_front(); total++;
        if ({temp_sense, temp_err, temp_valid, overtemp} !== {r.ts, r.err, r.valid, r.ot}) begin
            bad++; $display("FAIL reset_mid result: got ts=%h err=%b vld=%b ot=%b want ts=%h err=%b vld=%b ot=%b",
                            temp_sense, temp_err, temp_valid, overtemp, r.ts, r.err, r.valid, r.ot);
        end
    endtask

    initial begin
        test_reset();
        test_first_poll();
        test_addr_nack();
        test_back_to_back();
        test_overtemp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog");
    end

endmodule
